sram_sp_pwr_model: RTL and testbench

//  Parametrised single-port SRAM behavioural model with power management. It is the

---
 rtl/sram_sp_pwr_model_if.sv | 47 ++++
 rtl/sram_sp_pwr_model.sv | 182 ++++++++++++++++++
 tb/tb_sram_sp_pwr_model.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_pwr_model_if.sv
// ============================================================================
//  Module   : sram_sp_pwr_model_if
//  Purpose  : Bus bundle between an SRAM client (master) and the single-port
//             SRAM power-managed model (slave).
//  Signals  : sd           shutdown request, array contents lost
//             dslp         deep-sleep request, array contents retained
//             ceb          chip enable, active low
//             web          write enable, active low (1 = read)
//             a            word address
//             bweb         bit write enable, active low
//             d            write data
//             q            read data
//             pudelay_sd   shutdown state indicator incl. wake window
//             pudelay_dslp deep-sleep state indicator incl. wake window
//             err          one-cycle pulse on a rejected access
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_sp_pwr_model_if #(
    parameter int AW    = 12,
    parameter int WIDTH = 20
);
    logic             sd;
    logic             dslp;
    logic             ceb;
    logic             web;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] bweb;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             pudelay_sd;
    logic             pudelay_dslp;
    logic             err;

    modport master (
        output sd, dslp, ceb, web, a, bweb, d,
        input  q, pudelay_sd, pudelay_dslp, err
    );

    modport slave (
        input  sd, dslp, ceb, web, a, bweb, d,
        output q, pudelay_sd, pudelay_dslp, err
    );
endinterface

`default_nettype wire

// File: rtl/sram_sp_pwr_model.sv
// ============================================================================
//  Module   : sram_sp_pwr_model
//  Purpose  : Parametrised single-port SRAM behavioural model with shutdown /
//             deep-sleep power FSM, counted wake-up, bit-write mask,
//             configurable read latency and access-error flagging.
//  Ports    : clk_i   clock, all logic on rising edge
//             rstb_i  synchronous active-low reset
//             bus     sram_sp_pwr_model_if.slave (request, data, status)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_sp_pwr_model #(
    parameter int DEPTH       = 4096,
    parameter int WIDTH       = 20,
    parameter int AW          = $clog2(DEPTH),
    parameter int RD_LAT      = 1,
    parameter int PU_CYC_SD   = 16,
    parameter int PU_CYC_DSLP = 4
) (
    input  wire                   clk_i,
    input  wire                   rstb_i,
    sram_sp_pwr_model_if.slave    bus
);

    localparam int c_LAT    = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam int c_PU_MAX = (PU_CYC_SD > PU_CYC_DSLP) ? PU_CYC_SD : PU_CYC_DSLP;
    localparam int c_CW     = (c_PU_MAX > 1) ? $clog2(c_PU_MAX) : 1;

    localparam logic [c_CW-1:0] c_CNT_SD   = c_CW'(PU_CYC_SD - 1);
    localparam logic [c_CW-1:0] c_CNT_DSLP = c_CW'(PU_CYC_DSLP - 1);
    localparam logic [AW:0]     c_DEPTH_X  = (AW+1)'(DEPTH);

    localparam logic [2:0] c_ACTIVE    = 3'd0;
    localparam logic [2:0] c_DSLP_S    = 3'd1;
    localparam logic [2:0] c_SD_S      = 3'd2;
    localparam logic [2:0] c_WAKE_DSLP = 3'd3;
    localparam logic [2:0] c_WAKE_SD   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic             pud_sd_q, pud_sd_d;
    logic             pud_dslp_q, pud_dslp_d;
    logic             err_q;
    logic [WIDTH-1:0] q_q;

    logic             w_flush;
    logic             w_clear;
    logic             w_accept;
    logic             w_reject;
    logic             w_wr;
    logic             w_rd;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_LAT-1:0] pipe_vld_q;
    logic [WIDTH-1:0] pipe_data_q [c_LAT];

    // ------------------------------------------------------------------------
    // Power FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q    <= c_ACTIVE;
            cnt_q      <= '0;
            pud_sd_q   <= 1'b0;
            pud_dslp_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pud_sd_q   <= pud_sd_d;
            pud_dslp_q <= pud_dslp_d;
            err_q      <= w_reject;
        end
    end

    // ------------------------------------------------------------------------
    // Power FSM: next state and wake counter
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.sd) begin
            state_d = c_SD_S;
        end else begin
            case (state_q)
                c_ACTIVE:    if (bus.dslp) state_d = c_DSLP_S;
                c_DSLP_S:    if (!bus.dslp) state_d = c_WAKE_DSLP;
                c_WAKE_DSLP: begin
                    if (bus.dslp)           state_d = c_DSLP_S;
                    else if (cnt_q == '0)   state_d = c_ACTIVE;
                end
                c_SD_S:      state_d = c_WAKE_SD;
                // Deep-sleep requests are deliberately ignored until ACTIVE.
                c_WAKE_SD:   if (cnt_q == '0) state_d = c_ACTIVE;
                default:     state_d = c_ACTIVE;
            endcase
        end

        // Counter loads on wake entry; ACTIVE is reached on the edge where
        // the counter is already zero, giving exactly PU_CYC_* edges of wake.
        cnt_d = cnt_q;
        if (state_q == c_SD_S && state_d == c_WAKE_SD) begin
            cnt_d = c_CNT_SD;
        end else if (state_q == c_DSLP_S && state_d == c_WAKE_DSLP) begin
            cnt_d = c_CNT_DSLP;
        end else if ((state_q == c_WAKE_SD || state_q == c_WAKE_DSLP) && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Power FSM: outputs and access qualification
    // ------------------------------------------------------------------------
    always_comb begin
        pud_sd_d   = (state_d == c_SD_S)   || (state_d == c_WAKE_SD);
        pud_dslp_d = (state_d == c_DSLP_S) || (state_d == c_WAKE_DSLP);
        w_flush    = (state_d == c_SD_S)   || (state_d == c_DSLP_S);
        w_clear    = (state_d == c_SD_S)   && (state_q != c_SD_S);
        // Requiring state_d == ACTIVE rejects an access on the edge where
        // SD or DSLP rises.
        w_accept   = !bus.ceb && (state_q == c_ACTIVE) && (state_d == c_ACTIVE) &&
                     ({1'b0, bus.a} < c_DEPTH_X);
        w_reject   = !bus.ceb && !w_accept;
        w_wr       = w_accept && !bus.web;
        w_rd       = w_accept &&  bus.web;
    end

    // ------------------------------------------------------------------------
    // Array: no reset, cleared on shutdown entry, masked writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rstb_i) begin
            if (w_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (w_wr) begin
                mem_q[bus.a] <= (mem_q[bus.a] & bus.bweb) | (bus.d & ~bus.bweb);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: stage 0 captures the word at the request edge, Q loads
    // from the last stage, so Q changes exactly RD_LAT edges after request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstb_i || w_flush) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= w_rd;
            for (int i = 1; i < c_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_rd) begin
            pipe_data_q[0] <= mem_q[bus.a];
        end
        for (int i = 1; i < c_LAT; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstb_i || w_flush) begin
            q_q <= '0;
        end else if (pipe_vld_q[c_LAT-1]) begin
            q_q <= pipe_data_q[c_LAT-1];
        end
    end

    assign bus.q            = q_q;
    assign bus.pudelay_sd   = pud_sd_q;
    assign bus.pudelay_dslp = pud_dslp_q;
    assign bus.err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_sp_pwr_model.sv
// ============================================================================
//  Module   : tb_sram_sp_pwr_model
//  Purpose  : Directed self-checking bench for sram_sp_pwr_model.
//             Instance u_dut1 uses RD_LAT=1, instance u_dut2 uses RD_LAT=2.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_sp_pwr_model;

    logic clk;
    logic rstb;
    int   n_tests = 0;
    int   n_fail  = 0;

    sram_sp_pwr_model_if #(.AW(12), .WIDTH(20)) if1 ();
    sram_sp_pwr_model_if #(.AW(12), .WIDTH(20)) if2 ();

    sram_sp_pwr_model #(.DEPTH(4096), .WIDTH(20), .RD_LAT(1),
                        .PU_CYC_SD(16), .PU_CYC_DSLP(4)) u_dut1 (
        .clk_i  (clk),
        .rstb_i (rstb),
        .bus    (if1.slave)
    );

    sram_sp_pwr_model #(.DEPTH(4096), .WIDTH(20), .RD_LAT(2),
                        .PU_CYC_SD(16), .PU_CYC_DSLP(4)) u_dut2 (
        .clk_i  (clk),
        .rstb_i (rstb),
        .bus    (if2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if1.ceb = 1'b1; if1.web = 1'b1;
        if2.ceb = 1'b1; if2.web = 1'b1;
    endtask

    task automatic wr(input bit s, input logic [11:0] a, input logic [19:0] d,
                      input logic [19:0] bw);
        if (!s) begin
            if1.ceb = 1'b0; if1.web = 1'b0; if1.a = a; if1.d = d; if1.bweb = bw;
        end else begin
            if2.ceb = 1'b0; if2.web = 1'b0; if2.a = a; if2.d = d; if2.bweb = bw;
        end
        tick();
        idle();
    endtask

    task automatic rd(input bit s, input logic [11:0] a);
        if (!s) begin
            if1.ceb = 1'b0; if1.web = 1'b1; if1.a = a;
        end else begin
            if2.ceb = 1'b0; if2.web = 1'b1; if2.a = a;
        end
        tick();
        idle();
    endtask

    initial begin
        rstb = 1'b0;
        if1.sd = 1'b0; if1.dslp = 1'b0; if1.a = '0; if1.d = '0; if1.bweb = '1;
        if2.sd = 1'b0; if2.dslp = 1'b0; if2.a = '0; if2.d = '0; if2.bweb = '1;
        idle();
        tick();
        tick();
        rstb = 1'b1;

        // Reset state
        chk("rst_q",        32'(if1.q), 32'h0);
        chk("rst_pud_sd",   32'(if1.pudelay_sd), 32'h0);
        chk("rst_pud_dslp", 32'(if1.pudelay_dslp), 32'h0);
        chk("rst_err",      32'(if1.err), 32'h0);

        // 1: write then read, one-edge latency
        wr(0, 12'd5, 20'hABCDE, 20'h00000);
        rd(0, 12'd5);
        chk("t1_lat", 32'(if1.q), 32'h0);
        tick();
        chk("t1_rd",  32'(if1.q), 32'hABCDE);
        chk("t1_err", 32'(if1.err), 32'h0);

        // 2: bit-write mask
        wr(0, 12'd7, 20'hFFFFF, 20'h00000);
        wr(0, 12'd7, 20'h00000, 20'hFFF00);
        rd(0, 12'd7);
        tick();
        chk("t2_mask", 32'(if1.q), 32'hFFF00);

        // 3: deep sleep, retention, race with DSLP rise, counted wake
        wr(0, 12'd1, 20'h12345, 20'h00000);
        if1.dslp = 1'b1;
        if1.ceb = 1'b0; if1.web = 1'b0; if1.a = 12'd1; if1.d = 20'hFFFFF; if1.bweb = 20'h0;
        tick();
        idle();
        chk("t3_race_err", 32'(if1.err), 32'h1);
        chk("t3_pud_dslp", 32'(if1.pudelay_dslp), 32'h1);
        chk("t3_q_zero",   32'(if1.q), 32'h0);
        tick();
        chk("t3_err_pulse", 32'(if1.err), 32'h0);
        rd(0, 12'd1);
        chk("t3_sleep_err", 32'(if1.err), 32'h1);
        repeat (7) tick();
        if1.dslp = 1'b0;
        tick();
        chk("t3_wake_start", 32'(if1.pudelay_dslp), 32'h1);
        repeat (3) tick();
        chk("t3_wake_last", 32'(if1.pudelay_dslp), 32'h1);
        tick();
        chk("t3_awake", 32'(if1.pudelay_dslp), 32'h0);
        rd(0, 12'd1);
        tick();
        chk("t3_retained", 32'(if1.q), 32'h12345);

        // 4: shutdown clears the array, wake window rejects accesses
        wr(0, 12'd2, 20'h5A5A5, 20'h00000);
        if1.sd = 1'b1;
        tick();
        chk("t4_pud_sd", 32'(if1.pudelay_sd), 32'h1);
        chk("t4_q_zero", 32'(if1.q), 32'h0);
        repeat (9) tick();
        if1.sd = 1'b0;
        tick();
        chk("t4_wake_start", 32'(if1.pudelay_sd), 32'h1);
        rd(0, 12'd2);
        chk("t4_wake_err", 32'(if1.err), 32'h1);
        chk("t4_wake_q",   32'(if1.q), 32'h0);
        tick();
        chk("t4_err_pulse", 32'(if1.err), 32'h0);
        repeat (13) tick();
        chk("t4_wake_last", 32'(if1.pudelay_sd), 32'h1);
        tick();
        chk("t4_awake", 32'(if1.pudelay_sd), 32'h0);
        wr(0, 12'd3, 20'h11111, 20'h00000);
        rd(0, 12'd3);
        tick();
        chk("t4_new_data", 32'(if1.q), 32'h11111);
        rd(0, 12'd2);
        tick();
        chk("t4_cleared", 32'(if1.q), 32'h0);

        // 6: reset during wake aborts it; reset keeps array contents
        if1.sd = 1'b1;
        tick();
        if1.sd = 1'b0;
        tick();
        repeat (3) tick();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        chk("t6_pud_sd", 32'(if1.pudelay_sd), 32'h0);
        chk("t6_q",      32'(if1.q), 32'h0);
        wr(0, 12'd6, 20'h77777, 20'h00000);
        rd(0, 12'd6);
        chk("t6_no_err", 32'(if1.err), 32'h0);
        tick();
        chk("t6_active_rd", 32'(if1.q), 32'h77777);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        chk("t6_rst_q", 32'(if1.q), 32'h0);
        rd(0, 12'd6);
        tick();
        chk("t6_preserved", 32'(if1.q), 32'h77777);

        // 5: RD_LAT=2 back-to-back reads
        wr(1, 12'd0, 20'h00111, 20'h00000);
        wr(1, 12'd1, 20'h00222, 20'h00000);
        wr(1, 12'd2, 20'h00333, 20'h00000);
        if2.ceb = 1'b0; if2.web = 1'b1; if2.a = 12'd0;
        tick();
        if2.a = 12'd1;
        tick();
        chk("t5_lat", 32'(if2.q), 32'h0);
        if2.a = 12'd2;
        tick();
        idle();
        chk("t5_w0", 32'(if2.q), 32'h00111);
        tick();
        chk("t5_w1", 32'(if2.q), 32'h00222);
        tick();
        chk("t5_w2", 32'(if2.q), 32'h00333);
        tick();
        chk("t5_hold", 32'(if2.q), 32'h00333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
